// File: rtl/cl_cfg_mailbox_slv.sv
// cl_cfg_mailbox_slv: cfg-bus responder for one 256B slot.
// Provides ID/scratch/cycle registers and two mailbox FIFOs (H2F, F2H)
// with sticky overflow/underflow flags. Every request gets a one-cycle ack.
module cl_cfg_mailbox_slv #(
  parameter logic [31:0] ID_VALUE   = 32'h4D42_0001,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        sync_rst,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        cfg_wr,
  input  logic        cfg_rd,
  output logic        cfg_ack,
  output logic [31:0] cfg_rdata,
  output logic [31:0] h2f_data_o,
  output logic        h2f_v_o,
  input  logic        h2f_yumi_i,
  input  logic [31:0] f2h_data_i,
  input  logic        f2h_v_i,
  output logic        f2h_ready_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  // Index 0 is H2F (host pushes, fabric pops), index 1 is F2H.
  logic [1:0]    fifo_push;
  logic [1:0]    fifo_pop;
  logic [31:0]   fifo_wdata [2];
  logic [31:0]   fifo_head  [2];
  logic [CW-1:0] fifo_cnt   [2];

  logic          ack_reg;
  logic [31:0]   rdata_reg;
  logic [31:0]   scratch_reg;
  logic [31:0]   cycle_reg;
  logic          ovf_reg, ovf_next;
  logic          unf_reg, unf_next;

  logic [5:0]    reg_idx;
  logic          host_wr, host_rd;
  logic          h2f_full, f2h_full, f2h_empty;
  logic          h2f_push_req, f2h_pop_req;
  logic          ovf_err, unf_err;
  logic          clr_wr;
  logic [31:0]   rd_mux;
  logic [31:0]   status_word;
  logic          unused_addr_bits;

  assign reg_idx          = cfg_addr[7:2];
  assign unused_addr_bits = ^{cfg_addr[31:8], cfg_addr[1:0]};

  // A simultaneous wr+rd is a write; the read side is suppressed entirely.
  assign host_wr = cfg_wr;
  assign host_rd = cfg_rd & ~cfg_wr;

  // Full/empty use the registered counts, so same-cycle activity on the
  // other side never rescues a push to a full or a pop of an empty FIFO.
  assign h2f_full  = (fifo_cnt[0] == FULL_CNT);
  assign f2h_full  = (fifo_cnt[1] == FULL_CNT);
  assign f2h_empty = (fifo_cnt[1] == '0);

  assign h2f_push_req = host_wr && (reg_idx == 6'd2);
  assign f2h_pop_req  = host_rd && (reg_idx == 6'd3);
  assign clr_wr       = host_wr && (reg_idx == 6'd5);

  assign ovf_err = h2f_push_req & h2f_full;
  assign unf_err = f2h_pop_req & f2h_empty;

  assign fifo_push[0]  = h2f_push_req & ~h2f_full;
  assign fifo_pop[0]   = h2f_yumi_i & (fifo_cnt[0] != '0);
  assign fifo_wdata[0] = cfg_wdata;
  assign fifo_push[1]  = f2h_v_i & ~f2h_full;
  assign fifo_pop[1]   = f2h_pop_req & ~f2h_empty;
  assign fifo_wdata[1] = f2h_data_i;

  // Two identical circular-buffer FIFOs with first-word-fall-through heads.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [31:0]   mem [FIFO_DEPTH];
      logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
      logic [CW-1:0] count_reg, count_next;

      // Storage write; no reset so it maps onto plain memory.
      always_ff @(posedge clk) begin
        if (fifo_push[gi]) mem[wr_ptr_reg] <= fifo_wdata[gi];
      end

      // Next count: a push and pop together leave it unchanged.
      always_comb begin
        count_next = count_reg;
        if (fifo_push[gi] && !fifo_pop[gi]) count_next = count_reg + CW'(1);
        else if (!fifo_push[gi] && fifo_pop[gi]) count_next = count_reg - CW'(1);
      end

      // Pointers wrap naturally since the depth is a power of two.
      always_ff @(posedge clk) begin
        if (sync_rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (fifo_push[gi]) wr_ptr_reg <= wr_ptr_reg + PW'(1);
          if (fifo_pop[gi])  rd_ptr_reg <= rd_ptr_reg + PW'(1);
          count_reg <= count_next;
        end
      end

      assign fifo_head[gi] = mem[rd_ptr_reg];
      assign fifo_cnt[gi]  = count_reg;
    end
  endgenerate

  assign status_word = {8'h00, 8'(fifo_cnt[1]), 8'(fifo_cnt[0]),
                        4'h0, unf_reg, ovf_reg, f2h_empty, h2f_full};

  // Read data as seen at the request cycle.
  always_comb begin
    rd_mux = 32'hDEAD_BEEF;
    case (reg_idx)
      6'd0:    rd_mux = ID_VALUE;
      6'd1:    rd_mux = scratch_reg;
      6'd2:    rd_mux = 32'h0;
      6'd3:    rd_mux = f2h_empty ? 32'h0 : fifo_head[1];
      6'd4:    rd_mux = status_word;
      6'd5:    rd_mux = 32'h0;
      6'd6:    rd_mux = cycle_reg;
      default: rd_mux = 32'hDEAD_BEEF;
    endcase
  end

  // Sticky flags: a new error wins over a same-cycle W1C clear.
  always_comb begin
    ovf_next = (ovf_reg & ~(clr_wr & cfg_wdata[2])) | ovf_err;
    unf_next = (unf_reg & ~(clr_wr & cfg_wdata[3])) | unf_err;
  end

  // Register file, ack/rdata pipeline and free-running counter.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      ack_reg     <= 1'b0;
      rdata_reg   <= 32'h0;
      scratch_reg <= 32'h0;
      cycle_reg   <= 32'h0;
      ovf_reg     <= 1'b0;
      unf_reg     <= 1'b0;
    end else begin
      ack_reg   <= host_wr | host_rd;
      cycle_reg <= cycle_reg + 32'd1;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
      if (host_wr | host_rd) rdata_reg <= host_wr ? 32'h0 : rd_mux;
      if (host_wr && (reg_idx == 6'd1)) scratch_reg <= cfg_wdata;
    end
  end

  // Reset raised while an ack is due suppresses it immediately.
  assign cfg_ack     = ack_reg & ~sync_rst;
  assign cfg_rdata   = rdata_reg;
  assign h2f_data_o  = fifo_head[0];
  assign h2f_v_o     = (fifo_cnt[0] != '0);
  assign f2h_ready_o = ~f2h_full;

endmodule

// File: tb/tb_cl_cfg_mailbox_slv.sv
// Directed self-checking bench for cl_cfg_mailbox_slv.
module tb_cl_cfg_mailbox_slv;

  logic        clk = 1'b0;
  logic        sync_rst = 1'b1;
  logic [31:0] cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic        cfg_wr = 1'b0;
  logic        cfg_rd = 1'b0;
  logic        cfg_ack;
  logic [31:0] cfg_rdata;
  logic [31:0] h2f_data_o;
  logic        h2f_v_o;
  logic        h2f_yumi_i = 1'b0;
  logic [31:0] f2h_data_i = '0;
  logic        f2h_v_i = 1'b0;
  logic        f2h_ready_o;

  int test_cnt = 0;
  int fail_cnt = 0;

  cl_cfg_mailbox_slv dut (
    .clk         (clk),
    .sync_rst    (sync_rst),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_wr      (cfg_wr),
    .cfg_rd      (cfg_rd),
    .cfg_ack     (cfg_ack),
    .cfg_rdata   (cfg_rdata),
    .h2f_data_o  (h2f_data_o),
    .h2f_v_o     (h2f_v_o),
    .h2f_yumi_i  (h2f_yumi_i),
    .f2h_data_i  (f2h_data_i),
    .f2h_v_i     (f2h_v_i),
    .f2h_ready_o (f2h_ready_o)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request: driven at a negedge, sampled at the next posedge,
  // ack/rdata observed at the following negedge.
  task automatic cfg_req(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic ack, output logic [31:0] rdata);
    @(negedge clk);
    cfg_wr = wr; cfg_rd = rd; cfg_addr = addr; cfg_wdata = wdata;
    @(negedge clk);
    cfg_wr = 1'b0; cfg_rd = 1'b0;
    ack = cfg_ack; rdata = cfg_rdata;
    $display("[TB] %s%s 0x%02h wdata=0x%08h -> ack=%0b rdata=0x%08h",
             wr ? "wr" : "", rd ? "rd" : "", addr[7:0], wdata, ack, rdata);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic a; logic [31:0] d;
    cfg_req(1'b0, 1'b1, addr, 32'h0, a, d);
    check32({tag, "_ack"}, {31'h0, a}, 32'h1);
    check32(tag, d, exp);
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] addr, input logic [31:0] data);
    logic a; logic [31:0] d;
    cfg_req(1'b1, 1'b0, addr, data, a, d);
    check32({tag, "_ack"}, {31'h0, a}, 32'h1);
    check32({tag, "_rdata"}, d, 32'h0);
  endtask

  task automatic do_reset();
    sync_rst = 1'b1;
    repeat (3) @(negedge clk);
    check32("rst_ack", {31'h0, cfg_ack}, 32'h0);
    check32("rst_rdata", cfg_rdata, 32'h0);
    check32("rst_h2f_v", {31'h0, h2f_v_o}, 32'h0);
    check32("rst_f2h_rdy", {31'h0, f2h_ready_o}, 32'h1);
    sync_rst = 1'b0;
  endtask

  initial begin
    logic a; logic [31:0] d, c1, c2;

    do_reset();

    // ID, unmapped, byte-offset ignored
    rd_chk("id", 32'h00, 32'h4D42_0001);
    rd_chk("unmapped", 32'h40, 32'hDEAD_BEEF);
    rd_chk("id_b3", 32'h03, 32'h4D42_0001);

    // Scratch and wr+rd collision
    wr_chk("scr_wr", 32'h04, 32'hA5A5_5A5A);
    rd_chk("scr_rd", 32'h04, 32'hA5A5_5A5A);
    cfg_req(1'b1, 1'b1, 32'h04, 32'h1234_5678, a, d);
    check32("wrrd_ack", {31'h0, a}, 32'h1);
    check32("wrrd_rdata", d, 32'h0);
    rd_chk("scr_rd2", 32'h04, 32'h1234_5678);
    rd_chk("status0", 32'h10, 32'h0000_0002);

    // Cycle counter: request edges are two cycles apart
    cfg_req(1'b0, 1'b1, 32'h18, 32'h0, a, c1);
    cfg_req(1'b0, 1'b1, 32'h18, 32'h0, a, c2);
    check32("cycle_delta", c2 - c1, 32'd2);

    // H2F overflow: 17 pushes into depth 16
    for (int i = 0; i < 17; i++) wr_chk("h2f_push", 32'h08, 32'h100 + i);
    rd_chk("status_ovf", 32'h10, 32'h0000_1007);
    rd_chk("h2f_push_rd", 32'h08, 32'h0);

    // Drain H2F with back-to-back yumi
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check32("h2f_v", {31'h0, h2f_v_o}, 32'h1);
      check32("h2f_data", h2f_data_o, 32'h100 + i);
      $display("[TB] h2f pop %0d data=0x%08h", i, h2f_data_o);
      h2f_yumi_i = 1'b1;
    end
    @(negedge clk);
    h2f_yumi_i = 1'b0;
    check32("h2f_v_empty", {31'h0, h2f_v_o}, 32'h0);
    wr_chk("clr_ovf", 32'h14, 32'h4);
    rd_chk("status_clr_ovf", 32'h10, 32'h0000_0002);

    // F2H underflow and W1C
    rd_chk("f2h_unf_rd", 32'h0C, 32'h0);
    rd_chk("status_unf", 32'h10, 32'h0000_000A);
    wr_chk("clr_unf", 32'h14, 32'h8);
    rd_chk("status_clr_unf", 32'h10, 32'h0000_0002);

    // Streaming: fabric pushes 1..40, host pops every cycle one cycle behind
    for (int cyc = 0; cyc < 42; cyc++) begin
      @(negedge clk);
      if (cyc >= 2) begin
        check32("strm_ack", {31'h0, cfg_ack}, 32'h1);
        check32("strm_data", cfg_rdata, cyc - 1);
        $display("[TB] f2h pop rdata=0x%08h", cfg_rdata);
      end
      f2h_v_i    = (cyc < 40);
      f2h_data_i = cyc + 1;
      cfg_rd     = (cyc >= 1 && cyc <= 40);
      cfg_addr   = 32'h0C;
    end
    f2h_v_i = 1'b0; cfg_rd = 1'b0;
    rd_chk("status_strm", 32'h10, 32'h0000_0002);

    // Reset right after a read request: ack dropped, FIFOs flushed
    wr_chk("pre_rst_push", 32'h08, 32'h55);
    @(negedge clk);
    f2h_v_i = 1'b1; f2h_data_i = 32'h66;
    @(negedge clk);
    f2h_v_i = 1'b0;
    rd_chk("status_pre_rst", 32'h10, 32'h0001_0100);
    @(negedge clk);
    cfg_rd = 1'b1; cfg_addr = 32'h00;
    @(negedge clk);
    cfg_rd = 1'b0; sync_rst = 1'b1;
    #1;
    $display("[TB] rd 0x00 then reset -> ack=%0b", cfg_ack);
    check32("rst_mid_ack", {31'h0, cfg_ack}, 32'h0);
    @(negedge clk);
    check32("rst_mid_ack2", {31'h0, cfg_ack}, 32'h0);
    check32("rst_mid_h2f_v", {31'h0, h2f_v_o}, 32'h0);
    check32("rst_mid_f2h_rdy", {31'h0, f2h_ready_o}, 32'h1);
    sync_rst = 1'b0;
    rd_chk("status_post_rst", 32'h10, 32'h0000_0002);
    rd_chk("scr_post_rst", 32'h04, 32'h0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
